seq_shift_rotate_unit: RTL

//  Parametrised, clocked successor of the 8-bit combinational shift/rotate block.

---
 rtl/seq_shift_rotate_unit_if.sv | 31 +++
 rtl/seq_shift_rotate_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_shift_rotate_unit_if.sv
// Request/response bundle for seq_shift_rotate_unit: operand, op and amount in, result out.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface seq_shift_rotate_unit_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [1:0]       select;
    logic [AMT_W-1:0] amt;
    logic             fill_lsb;
    logic             fill_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             busy;

    // requester side (register-file read / writeback stage)
    modport master (
        output in_valid, x, select, amt, fill_lsb, fill_msb, out_ready,
        input  in_ready, out_valid, y, busy
    );

    // shift/rotate unit side
    modport slave (
        input  in_valid, x, select, amt, fill_lsb, fill_msb, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/seq_shift_rotate_unit.sv
// Sequential shift/rotate (shl/shr/rotl/rotr) of a WIDTH-bit operand; optional barrel stage via `SEQ_SHIFT_BARREL_EN.
// Latency: amt+1 cycles from accept to out_valid (barrel build: 2 cycles, or 1 when amt=0).
// Backpressure: one request in flight; in_ready low until the result is taken, y held while out_ready is low.
module seq_shift_rotate_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_shift_rotate_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] d_q;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic             fill_lsb_q;
    logic             fill_msb_q;
    logic [WIDTH-1:0] step_d;

`ifdef SEQ_SHIFT_BARREL_EN
    // Amount is widened by one bit so WIDTH itself is representable for the modulo.
    localparam logic [AMT_W:0] WIDTH_V = (AMT_W+1)'(WIDTH);
    logic [AMT_W:0]   cnt_ext;
    logic [AMT_W:0]   rot_amt;
    logic [WIDTH-1:0] ones;

    // Full cnt_q-position operation in one step; shifts past WIDTH leave only fill bits,
    // rotates reduce modulo WIDTH, so the result matches cnt_q single-bit steps.
    always_comb begin
        cnt_ext = {1'b0, cnt_q};
        rot_amt = cnt_ext % WIDTH_V;
        ones    = {WIDTH{1'b1}};
        step_d  = d_q;
        case (sel_q)
            OP_SHL:  step_d = (d_q << cnt_q) | (~(ones << cnt_q) & {WIDTH{fill_lsb_q}});
            OP_SHR:  step_d = (d_q >> cnt_q) | (~(ones >> cnt_q) & {WIDTH{fill_msb_q}});
            OP_ROTL: step_d = (d_q << rot_amt) | (d_q >> (WIDTH_V - rot_amt));
            OP_ROTR: step_d = (d_q >> rot_amt) | (d_q << (WIDTH_V - rot_amt));
            default: step_d = d_q;
        endcase
    end
`else
    // One bit position per cycle.
    always_comb begin
        step_d = d_q;
        case (sel_q)
            OP_SHL:  step_d = {d_q[WIDTH-2:0], fill_lsb_q};
            OP_SHR:  step_d = {fill_msb_q, d_q[WIDTH-1:1]};
            OP_ROTL: step_d = {d_q[WIDTH-2:0], d_q[WIDTH-1]};
            OP_ROTR: step_d = {d_q[0], d_q[WIDTH-1:1]};
            default: step_d = d_q;
        endcase
    end
`endif

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, iterate in SHIFT, hold in DONE until the consumer takes y.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = (bus.amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
`ifdef SEQ_SHIFT_BARREL_EN
                state_d = DONE;
`else
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q == SHIFT) || (state_q == DONE);
    end

    // Datapath: capture the request on accept, then step the data register while in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q        <= '0;
            cnt_q      <= '0;
            sel_q      <= OP_SHL;
            fill_lsb_q <= 1'b0;
            fill_msb_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        d_q        <= bus.x;
                        cnt_q      <= bus.amt;
                        sel_q      <= bus.select;
                        fill_lsb_q <= bus.fill_lsb;
                        fill_msb_q <= bus.fill_msb;
                    end
                end
                SHIFT: begin
                    d_q <= step_d;
`ifdef SEQ_SHIFT_BARREL_EN
                    cnt_q <= '0;
`else
                    cnt_q <= cnt_q - AMT_W'(1);
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Result is the data register itself, so it cannot move while DONE waits on out_ready.
    assign bus.y = d_q;

endmodule
